pipelined_addsub_acc: RTL

Parametrised successor to the fixed 16-bit register-plus-adder datapath. Two-stage pipelined add/subtract/accumulate unit of configurable width, with valid/ready handshakes on input and output, a signed-overflow flag and an internal accumulator with read-and-clear. Sits between an operand producer and a result consumer in the arithmetic datapath. Sustains one operation per cycle under no back-pressure.

---
 rtl/pipelined_addsub_acc_pkg.sv | 14 +
 rtl/pipelined_addsub_acc_if.sv | 33 +++
 rtl/pipelined_addsub_acc_dff_nbit.sv | 24 ++
 rtl/pipelined_addsub_acc.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pipelined_addsub_acc_pkg.sv
// Shared definitions for the pipelined add/subtract/accumulate unit:
// operation encoding, the op type and the default datapath width.
package pipelined_addsub_acc_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD = 2'b00;
    localparam op_t OP_SUB = 2'b01;
    localparam op_t OP_ACC = 2'b10;
    localparam op_t OP_CLR = 2'b11;

endpackage

// File: rtl/pipelined_addsub_acc_if.sv
// Operand/result handshake bundle for pipelined_addsub_acc.
//   in_valid/in_ready   : operand beat handshake (d_a, d_b, cin, op)
//   out_valid/out_ready : result beat handshake (sum, cout, ovf)
// master = producer/consumer side, slave = the arithmetic unit.
interface pipelined_addsub_acc_if
    import pipelined_addsub_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_a;
    logic [WIDTH-1:0] d_b;
    logic             cin;
    op_t              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, d_a, d_b, cin, op, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, d_a, d_b, cin, op, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipelined_addsub_acc_dff_nbit.sv
// WIDTH-bit register with load enable and synchronous active-low reset.
//   clk  : clock          rstn : sync reset, clears q
//   en   : load enable    d/q  : data in / registered data out
module dff_nbit
    import pipelined_addsub_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipelined_addsub_acc.sv
// Two-stage pipelined add/subtract/accumulate unit with valid/ready on both
// sides, signed-overflow flag and an internal read-and-clear accumulator.
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset, drops all in-flight beats and acc
//   bus  : slave side of the operand/result handshake bundle
// S1 captures an operand beat; S2 computes from S1 and acc and holds the
// result until the consumer takes it. At most two beats are buffered.
module pipelined_addsub_acc
    import pipelined_addsub_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rstn,
    pipelined_addsub_acc_if.slave bus
);

    localparam int unsigned S1_W  = 2 * WIDTH + 3;
    localparam int unsigned S2_W  = WIDTH + 2;
    localparam int unsigned SUM_W = WIDTH + 1;

    logic             s1_valid;
    logic             out_valid_q;
    logic             s2_ready_c;
    logic             s2_load_c;
    logic             in_fire_c;
    logic             acc_load_c;

    logic [S1_W-1:0]  s1_d;
    logic [S1_W-1:0]  s1_q;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    op_t              s1_op;

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d_c;

    logic [WIDTH-1:0] x_c;
    logic [WIDTH-1:0] y_c;
    logic             c_c;
    logic [SUM_W-1:0] full_c;
    logic [WIDTH-1:0] res_sum_c;
    logic             res_cout_c;
    logic             res_ovf_c;

    logic [S2_W-1:0]  s2_d;
    logic [S2_W-1:0]  s2_q;

    // Handshake: S1 may refill in the same cycle it advances into S2.
    assign s2_ready_c   = !out_valid_q || bus.out_ready;
    assign s2_load_c    = s1_valid && s2_ready_c;
    assign bus.in_ready = !s1_valid || s2_ready_c;
    assign in_fire_c    = bus.in_valid && bus.in_ready;

    // Stage 1 operand register.
    assign s1_d = {bus.d_a, bus.d_b, bus.cin, bus.op};

    dff_nbit #(.WIDTH(S1_W)) u_s1_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (in_fire_c),
        .d    (s1_d),
        .q    (s1_q)
    );

    assign {s1_a, s1_b, s1_cin, s1_op} = s1_q;

    // Stage 1 occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
        end else if (in_fire_c) begin
            s1_valid <= 1'b1;
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2 occupancy.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
        end else if (s2_load_c) begin
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Operand steering and adder. SUB feeds ~b with carry 1, so the
    // same-sign overflow test on the adder inputs covers every op.
    always_comb begin
        x_c = s1_a;
        y_c = s1_b;
        c_c = s1_cin;
        case (s1_op)
            OP_SUB: begin
                y_c = ~s1_b;
                c_c = 1'b1;
            end
            OP_ACC: begin
                x_c = acc_q;
                y_c = s1_a;
            end
            default: begin
            end
        endcase

        full_c     = {1'b0, x_c} + {1'b0, y_c} + SUM_W'(c_c);
        res_sum_c  = full_c[WIDTH-1:0];
        res_cout_c = full_c[WIDTH];
        res_ovf_c  = (x_c[WIDTH-1] == y_c[WIDTH-1]) &&
                     (res_sum_c[WIDTH-1] != x_c[WIDTH-1]);

        if (s1_op == OP_CLR) begin
            res_sum_c  = acc_q;
            res_cout_c = 1'b0;
            res_ovf_c  = 1'b0;
        end
    end

    // Accumulator moves only when an ACC/CLR beat actually enters S2.
    assign acc_load_c = s2_load_c && ((s1_op == OP_ACC) || (s1_op == OP_CLR));
    assign acc_d_c    = (s1_op == OP_CLR) ? '0 : res_sum_c;

    dff_nbit #(.WIDTH(WIDTH)) u_acc_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (acc_load_c),
        .d    (acc_d_c),
        .q    (acc_q)
    );

    // Stage 2 result register.
    assign s2_d = {res_sum_c, res_cout_c, res_ovf_c};

    dff_nbit #(.WIDTH(S2_W)) u_s2_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (s2_load_c),
        .d    (s2_d),
        .q    (s2_q)
    );

    assign {bus.sum, bus.cout, bus.ovf} = s2_q;
    assign bus.out_valid                = out_valid_q;

endmodule
